// File: rtl/sm4_round_engine_pkg.sv
// Shared SM4 constants, the state encoding and the round primitives
// (S-box layer tau, linear transform L, 32-bit rotate).
package sm4_round_engine_pkg;

    localparam int NUM_ROUNDS = 32;
    localparam int CNT_W      = $clog2(NUM_ROUNDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] sbox_tau(input logic [31:0] b);
        return {SBOX[b[31:24]], SBOX[b[23:16]], SBOX[b[15:8]], SBOX[b[7:0]]};
    endfunction

    function automatic logic [31:0] lin_l(input logic [31:0] b);
        return b ^ rotl32(b, 2) ^ rotl32(b, 10) ^ rotl32(b, 18) ^ rotl32(b, 24);
    endfunction

endpackage

// File: rtl/sm4_round_engine_if.sv
// Block-in / result-out valid-ready bus between the mode wrapper and the round engine.
interface sm4_round_engine_if;
    logic         in_valid;
    logic         in_ready;
    logic         in_decrypt;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    modport master (
        output in_valid, in_decrypt, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_decrypt, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/sm4_round_engine_round_comb.sv
// One combinational SM4 round: X' = {X1, X2, X3, X0 ^ T(X1 ^ X2 ^ X3 ^ rk)}.
module sm4_round_comb
    import sm4_round_engine_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [31:0]  rk_i,
    output logic [127:0] state_o
);
    logic [31:0] x0, x1, x2, x3, t_val;

    assign {x0, x1, x2, x3} = state_i;
    assign t_val   = lin_l(sbox_tau(x1 ^ x2 ^ x3 ^ rk_i));
    assign state_o = {x1, x2, x3, x0 ^ t_val};
endmodule

// File: rtl/sm4_round_engine.sv
// Iterative SM4 datapath: ROUNDS_PER_CYCLE unrolled rounds per clock, 32 rounds total.
// IDLE: wait for a block | RUN: apply rounds | DONE: hold result until taken
module sm4_round_engine
    import sm4_round_engine_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush_i,
    input  logic [1023:0]       rk_flat_i,
    sm4_round_engine_if.slave   bus_if,
    output logic                busy_o
);
    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
          ROUNDS_PER_CYCLE == 4 || ROUNDS_PER_CYCLE == 8)) begin : g_bad_rpc
        $error("sm4_round_engine: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [127:0]       data_q, data_d;
    logic               dec_q, dec_d;
    logic [127:0]       out_q, out_d;

    logic               accept, step, last_step;
    logic [127:0]       chain [ROUNDS_PER_CYCLE+1];
    logic [127:0]       res;

    assign accept    = (state_q == IDLE) && bus_if.in_valid && !flush_i;
    assign step      = (state_q == RUN) && !flush_i;
    assign last_step = (cnt_q == CNT_W'(NUM_ROUNDS - ROUNDS_PER_CYCLE));

    // Key index for each unrolled stage; decrypt walks the schedule backwards.
    assign chain[0] = data_q;
    for (genvar s = 0; s < ROUNDS_PER_CYCLE; s++) begin : g_round
        logic [CNT_W-1:0] j_idx, k_idx;
        assign j_idx = cnt_q + CNT_W'(s);
        assign k_idx = dec_q ? (CNT_W'(NUM_ROUNDS - 1) - j_idx) : j_idx;
        sm4_round_comb u_round (
            .state_i (chain[s]),
            .rk_i    (rk_flat_i[32*k_idx +: 32]),
            .state_o (chain[s+1])
        );
    end

    assign res = chain[ROUNDS_PER_CYCLE];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (bus_if.in_valid)  state_d = RUN;
                RUN:     if (last_step)        state_d = DONE;
                DONE:    if (bus_if.out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        bus_if.in_ready  = 1'b0;
        bus_if.out_valid = 1'b0;
        busy_o           = 1'b0;
        case (state_q)
            IDLE: bus_if.in_ready = 1'b1;
            RUN:  busy_o = 1'b1;
            DONE: begin
                bus_if.out_valid = 1'b1;
                busy_o           = 1'b1;
            end
            default: ;
        endcase
    end

    // The counter stops at its final value rather than stepping past 31.
    always_comb begin
        cnt_d  = cnt_q;
        data_d = data_q;
        dec_d  = dec_q;
        out_d  = out_q;
        if (accept) begin
            cnt_d  = '0;
            data_d = bus_if.in_data;
            dec_d  = bus_if.in_decrypt;
        end else if (step) begin
            data_d = res;
            if (last_step) out_d = {res[31:0], res[63:32], res[95:64], res[127:96]};
            else           cnt_d = cnt_q + CNT_W'(ROUNDS_PER_CYCLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            data_q <= '0;
            dec_q  <= 1'b0;
            out_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            data_q <= data_d;
            dec_q  <= dec_d;
            out_q  <= out_d;
        end
    end

    assign bus_if.out_data = out_q;
endmodule

// File: tb/tb_sm4_round_engine.sv
// Runs four engines (1, 2, 4, 8 rounds per cycle) in lockstep against known answers
// and an independent SM4 model with its own key schedule.
module tb_sm4_round_engine;
    import sm4_round_engine_pkg::*;

    localparam logic [127:0] KAT_KEY = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] KAT_CT  = 128'h681edf34d206965e86b3e94f536e4246;
    localparam int LAT [4] = '{32, 16, 8, 4};

    logic           clk = 1'b0;
    logic           rst_n, flush, in_valid, in_decrypt, out_ready;
    logic [127:0]   in_data;
    logic [1023:0]  rk_flat;
    logic [3:0]     ov, ir, bz;
    logic [127:0]   od [4];
    logic [31:0]    rk_m [32];
    logic [127:0]   sb_q [4][$];
    logic [1023:0]  rk_lock;
    int             tests = 0;
    int             fails = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        sm4_round_engine_if bus ();
        assign bus.in_valid   = in_valid;
        assign bus.in_decrypt = in_decrypt;
        assign bus.in_data    = in_data;
        assign bus.out_ready  = out_ready;
        assign ov[g] = bus.out_valid;
        assign ir[g] = bus.in_ready;
        assign od[g] = bus.out_data;
        sm4_round_engine #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush_i   (flush),
            .rk_flat_i (rk_flat),
            .bus_if    (bus),
            .busy_o    (bz[g])
        );
    end

    // Round keys must not move while any engine holds a block.
    always @(posedge clk) begin
        if (bz == 4'b0) rk_lock <= rk_flat;
        else if (rk_flat !== rk_lock) begin
            fails++;
            $display("FAIL rk_stable: rk_flat changed while busy=%b", bz);
        end
    end

    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] tau_m(input logic [31:0] b);
        return {SBOX[b[31:24]], SBOX[b[23:16]], SBOX[b[15:8]], SBOX[b[7:0]]};
    endfunction

    task automatic expand_key(input logic [127:0] mk);
        logic [31:0] k [36];
        logic [31:0] ck, b;
        k[0] = mk[127:96] ^ 32'ha3b1bac6;
        k[1] = mk[95:64]  ^ 32'h56aa3350;
        k[2] = mk[63:32]  ^ 32'h677d9197;
        k[3] = mk[31:0]   ^ 32'hb27022dc;
        for (int i = 0; i < 32; i++) begin
            ck = {8'((4*i)*7), 8'((4*i+1)*7), 8'((4*i+2)*7), 8'((4*i+3)*7)};
            b  = tau_m(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
            k[i+4] = k[i] ^ b ^ rl(b, 13) ^ rl(b, 23);
            rk_m[i] = k[i+4];
            rk_flat[32*i +: 32] = k[i+4];
        end
    endtask

    function automatic logic [127:0] sm4_model(input logic [127:0] blk, input bit dec);
        logic [31:0] x [36];
        logic [31:0] kk, b;
        {x[0], x[1], x[2], x[3]} = blk;
        for (int j = 0; j < 32; j++) begin
            kk = dec ? rk_m[31-j] : rk_m[j];
            b  = tau_m(x[j+1] ^ x[j+2] ^ x[j+3] ^ kk);
            x[j+4] = x[j] ^ b ^ rl(b, 2) ^ rl(b, 10) ^ rl(b, 18) ^ rl(b, 24);
        end
        return {x[35], x[34], x[33], x[32]};
    endfunction

    // Offers one block for a single cycle once every engine is idle; returns just after the accept edge.
    task automatic accept_block(input logic [127:0] blk, input bit dec, input logic [127:0] exp_v);
        int w = 0;
        while (ir != 4'hf && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (ir != 4'hf) begin
            tests++; fails++;
            $display("FAIL accept_wait: in_ready=%b, want 1111", ir);
        end
        in_valid = 1'b1; in_data = blk; in_decrypt = dec;
        for (int k = 0; k < 4; k++) sb_q[k].push_back(exp_v);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_block(input logic [127:0] blk, input bit dec, input logic [127:0] exp_v, input string name);
        bit [3:0] done = '0;
        logic [127:0] want;
        accept_block(blk, dec, exp_v);
        for (int n = 1; n <= 40 && done != 4'hf; n++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                if (!done[k]) begin
                    if (ov[k]) begin
                        done[k] = 1'b1;
                        tests++;
                        if (n != LAT[k]) begin
                            fails++;
                            $display("FAIL %s_latency rpc=%0d: got %0d cycles, want %0d", name, 1 << k, n, LAT[k]);
                        end
                        want = (sb_q[k].size() > 0) ? sb_q[k].pop_front() : 'x;
                        tests++;
                        if (od[k] !== want) begin
                            fails++;
                            $display("FAIL %s_data rpc=%0d: got %h, want %h", name, 1 << k, od[k], want);
                        end
                    end else begin
                        tests++;
                        if (ir[k] !== 1'b0) begin
                            fails++;
                            $display("FAIL %s_in_ready_run rpc=%0d: got %b, want 0", name, 1 << k, ir[k]);
                        end
                    end
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (!done[k]) begin
                tests++; fails++;
                $display("FAIL %s_timeout rpc=%0d: out_valid never rose", name, 1 << k);
            end
        end
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (ir[k] !== 1'b1 || ov[k] !== 1'b0) begin
                fails++;
                $display("FAIL %s_return_idle rpc=%0d: in_ready=%b out_valid=%b, want 1/0", name, 1 << k, ir[k], ov[k]);
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (ov[k] !== 1'b0 || ir[k] !== 1'b1 || bz[k] !== 1'b0 || od[k] !== 128'h0) begin
                fails++;
                $display("FAIL reset_state rpc=%0d: valid=%b ready=%b busy=%b data=%h, want 0/1/0/0",
                         1 << k, ov[k], ir[k], bz[k], od[k]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_kat_encrypt();
        expand_key(KAT_KEY);
        run_block(KAT_KEY, 1'b0, KAT_CT, "kat_enc");
    endtask

    task automatic test_kat_decrypt();
        run_block(KAT_CT, 1'b1, KAT_KEY, "kat_dec");
    endtask

    task automatic test_unroll_sweep();
        logic [127:0] mk, blk;
        bit dec;
        for (int i = 0; i < 100; i++) begin
            mk  = {$urandom, $urandom, $urandom, $urandom};
            blk = {$urandom, $urandom, $urandom, $urandom};
            dec = 1'($urandom_range(0, 1));
            expand_key(mk);
            run_block(blk, dec, sm4_model(blk, dec), "sweep");
        end
    endtask

    task automatic test_backpressure();
        bit [3:0] done = '0;
        logic [127:0] held [4];
        logic [127:0] want;
        expand_key(KAT_KEY);
        out_ready = 1'b0;
        accept_block(KAT_KEY, 1'b0, KAT_CT);
        for (int n = 1; n <= 40 && done != 4'hf; n++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                if (!done[k] && ov[k]) begin
                    done[k] = 1'b1;
                    held[k] = od[k];
                    want = (sb_q[k].size() > 0) ? sb_q[k].pop_front() : 'x;
                    tests++;
                    if (od[k] !== want) begin
                        fails++;
                        $display("FAIL bp_data rpc=%0d: got %h, want %h", 1 << k, od[k], want);
                    end
                end
            end
        end
        if (done != 4'hf) begin
            tests++; fails++;
            $display("FAIL bp_timeout: done=%b, want 1111", done);
        end
        repeat (10) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                tests++;
                if (ov[k] !== 1'b1 || od[k] !== held[k] || ir[k] !== 1'b0) begin
                    fails++;
                    $display("FAIL bp_hold rpc=%0d: valid=%b ready=%b data=%h, want 1/0/%h",
                             1 << k, ov[k], ir[k], od[k], held[k]);
                end
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (ov[k] !== 1'b0 || ir[k] !== 1'b1) begin
                fails++;
                $display("FAIL bp_release rpc=%0d: valid=%b ready=%b, want 0/1", 1 << k, ov[k], ir[k]);
            end
        end
    endtask

    task automatic test_flush();
        expand_key(KAT_KEY);
        out_ready = 1'b0;
        accept_block(KAT_KEY, 1'b0, KAT_CT);
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                tests++;
                if (ov[k] !== 1'(n >= LAT[k])) begin
                    fails++;
                    $display("FAIL flush_pre_valid rpc=%0d cyc=%0d: got %b, want %b", 1 << k, n, ov[k], n >= LAT[k]);
                end
            end
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (ov[k] !== 1'b0 || ir[k] !== 1'b1 || bz[k] !== 1'b0) begin
                fails++;
                $display("FAIL flush_abort rpc=%0d: valid=%b ready=%b busy=%b, want 0/1/0", 1 << k, ov[k], ir[k], bz[k]);
            end
            sb_q[k].delete();
        end
        in_valid = 1'b1; flush = 1'b1; in_data = KAT_KEY; in_decrypt = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (bz[k] !== 1'b0 || ir[k] !== 1'b1) begin
                fails++;
                $display("FAIL flush_blocks_accept rpc=%0d: busy=%b ready=%b, want 0/1", 1 << k, bz[k], ir[k]);
            end
        end
        out_ready = 1'b1;
        run_block(KAT_KEY, 1'b0, KAT_CT, "after_flush");
    endtask

    task automatic test_reset_mid_run();
        expand_key(KAT_KEY);
        accept_block(KAT_KEY, 1'b0, KAT_CT);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (ov[k] !== 1'b0 || ir[k] !== 1'b1 || od[k] !== 128'h0 || bz[k] !== 1'b0) begin
                fails++;
                $display("FAIL reset_mid_run rpc=%0d: valid=%b ready=%b busy=%b data=%h, want 0/1/0/0",
                         1 << k, ov[k], ir[k], bz[k], od[k]);
            end
            sb_q[k].delete();
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_block(KAT_KEY, 1'b0, KAT_CT, "after_reset");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_decrypt = 1'b0;
        out_ready = 1'b1; in_data = '0; rk_flat = '0;
        test_reset();
        test_kat_encrypt();
        test_kat_decrypt();
        test_unroll_sweep();
        test_backpressure();
        test_flush();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
